// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: forward AES SubBytes over a 128-bit state, LANES bytes per cycle,
// with valid/ready handshakes on both sides.  Revision 1.0
`default_nettype none

module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign dout = SBOX[din];
endmodule

module sub_bytes_seq #(
   parameter int LANES = 4   // 1, 2, 4, 8 or 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   localparam int NBEATS = 16 / LANES;
   localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, next;
   logic [CW-1:0] cnt;
   logic [NBEATS-1:0][8*LANES-1:0] src_reg;
   logic [NBEATS-1:0][8*LANES-1:0] res_reg;
   logic [8*LANES-1:0] lane_in;
   logic [8*LANES-1:0] lane_out;
   logic accept;
   logic last;

   // Beat cnt covers bytes LANES*cnt .. LANES*cnt+LANES-1, low bytes first.
   assign lane_in  = src_reg[cnt];
   assign last     = (cnt == CW'(NBEATS - 1));
   assign out_data = res_reg;
   assign busy     = (state == S_BUSY);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      aes_sbox u_sbox (
         .din  (lane_in[8*k +: 8]),
         .dout (lane_out[8*k +: 8])
      );
   end

   always_comb begin
      next   = state;
      accept = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               accept = 1'b1;
               next   = S_BUSY;
            end
         end
         S_BUSY: begin
            if (last) next = S_DONE;
         end
         S_DONE: begin
            if (out_ready) next = S_IDLE;
         end
         default: next = S_IDLE;
      endcase
   end

   // in_ready/out_valid are registered from the next state so both are low during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         cnt       <= '0;
         src_reg   <= '0;
         res_reg   <= '0;
      end else begin
         state     <= next;
         in_ready  <= (next == S_IDLE);
         out_valid <= (next == S_DONE);
         if (accept) begin
            src_reg <= in_data;
            cnt     <= '0;
         end
         if (state == S_BUSY) begin
            res_reg[cnt] <= lane_out;
            cnt          <= last ? '0 : cnt + 1'b1;
         end
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
// tb_sub_bytes_seq: directed and randomized checks of sub_bytes_seq for LANES = 1, 4 and 16.
// Revision 1.0
`default_nettype none

module tb_sub_bytes_seq;
   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [127:0] in_data;
   logic         out_ready;
   logic         ir [3];
   logic         ov [3];
   logic [127:0] od [3];
   logic         bz [3];

   int errors = 0;
   int checks = 0;
   int nbeats_of [3] = '{16, 4, 1};
   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;
   vec_t vecs [4];

   sub_bytes_seq #(.LANES(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
   sub_bytes_seq #(.LANES(4)) u_l4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
   sub_bytes_seq #(.LANES(16)) u_l16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // S-box derived from GF(2^8) inversion plus the affine map, independent of the RTL table.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b  = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [7:0] r = v;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_tables();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sb[x]  = s;
         isb[s] = 8'(x);
      end
   endtask

   task automatic wait_ready(input int d);
      int n = 0;
      while (!ir[d] && n < 60) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("in_ready_timeout_dut%0d", d), {127'b0, ir[d]}, 128'd1);
   endtask

   task automatic run_main(input logic [127:0] din, output logic [127:0] got, output int lat);
      wait_ready(1);
      in_valid = 1'b1;
      in_data  = din;
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_after_accept", {127'b0, bz[1]}, 128'd1);
      lat = 0;
      while (!ov[1] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      got = od[1];
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [127:0] got, expv, p, x;
      int           lat;
      int           nout, phase, t_out [2], lats [3];
      logic [127:0] d_out [2];
      logic         prev_ir;

      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      build_tables();
      vecs[0] = '{128'h0, {16{8'h63}}};
      vecs[1] = '{128'h00112233_44556677_8899aabb_ccddeeff, 128'h638293c3_1bfc33f5_c4eeacea_4bc12816};
      vecs[2] = '{128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'h76abd7fe_2b670130_c56f6bf2_7b777c63};
      vecs[3] = '{{16{8'hff}}, {16{8'h16}}};

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_in_ready_%0d", d), {127'b0, ir[d]}, 128'd0);
         check($sformatf("rst_out_valid_%0d", d), {127'b0, ov[d]}, 128'd0);
         check($sformatf("rst_out_data_%0d", d), od[d], 128'd0);
         check($sformatf("rst_busy_%0d", d), {127'b0, bz[d]}, 128'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_release", {127'b0, ir[1]}, 128'd1);

      // Table vectors (T1, T2 and extra patterns)
      for (int i = 0; i < 4; i++) begin
         run_main(vecs[i].din, got, lat);
         check($sformatf("vec%0d_data", i), got, vecs[i].dout);
         check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
         pop();
      end

      // T3: output held under backpressure
      run_main(vecs[1].din, got, lat);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("hold_data", od[1], vecs[1].dout);
         check("hold_valid", {127'b0, ov[1]}, 128'd1);
         check("hold_in_ready", {127'b0, ir[1]}, 128'd0);
      end
      pop();
      check("pop_out_valid", {127'b0, ov[1]}, 128'd0);
      check("pop_in_ready", {127'b0, ir[1]}, 128'd1);
      check("pop_data_kept", od[1], vecs[1].dout);

      // T4: back-to-back with in_valid held and out_ready high
      wait_ready(1);
      out_ready = 1'b1; in_valid = 1'b1; in_data = {16{8'h01}};
      phase = 0; nout = 0; prev_ir = 1'b1;
      t_out = '{0, 0}; d_out = '{128'h0, 128'h0};
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ov[1]) begin
            if (nout < 2) begin
               t_out[nout] = c;
               d_out[nout] = od[1];
            end
            nout++;
         end
         if (prev_ir && !ir[1]) begin
            if (phase == 0) in_data = vecs[1].din;
            else in_valid = 1'b0;
            phase++;
         end
         prev_ir = ir[1];
      end
      out_ready = 1'b0;
      check("b2b_count", 128'(nout), 128'd2);
      check("b2b_first", d_out[0], {16{8'h7c}});
      check("b2b_second", d_out[1], vecs[1].dout);
      check("b2b_spacing", 128'(t_out[1] - t_out[0]), 128'd6);

      // T5: reset mid-BUSY after beat 2
      wait_ready(1);
      in_valid = 1'b1; in_data = 128'h0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_reset_busy", {127'b0, bz[1]}, 128'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {127'b0, ov[1]}, 128'd0);
      check("mid_rst_out_data", od[1], 128'd0);
      check("mid_rst_busy", {127'b0, bz[1]}, 128'd0);
      check("mid_rst_in_ready", {127'b0, ir[1]}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_main(vecs[1].din, got, lat);
      check("post_rst_data", got, vecs[1].dout);
      check("post_rst_latency", 128'(lat), 128'd4);
      pop();

      // T6: random blocks through the inverse S-box, all three lane widths in lockstep
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int b = 0; b < 1000; b++) begin
         p = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < 16; i++) x[8*i +: 8] = isb[p[8*i +: 8]];
         for (int d = 0; d < 3; d++) wait_ready(d);
         in_valid = 1'b1; in_data = x;
         @(negedge clk);
         in_valid = 1'b0;
         lats = '{-1, -1, -1};
         for (int c = 1; c <= 40 && (lats[0] < 0 || lats[1] < 0 || lats[2] < 0); c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++)
               if (ov[d] && lats[d] < 0) lats[d] = c;
         end
         for (int d = 0; d < 3; d++) begin
            check($sformatf("rand%0d_dut%0d_data", b, d), od[d], p);
            check($sformatf("rand%0d_dut%0d_latency", b, d), 128'(lats[d]), 128'(nbeats_of[d]));
         end
         pop();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
